// File: rtl/acq_readout_ctrl.sv
// acq_readout_ctrl
//   Arms an acquisition, waits for a fresh record, then reads the sample RAM
//   back channel by channel and streams one byte per sample to the host.
//
// Ports
//   clk, reset             clock (rising edge), asynchronous active-high reset
//   arm, auto_rearm, abort  control: start, repeat after readout, cancel
//   chan_mask, nsmp        channels to read, samples per channel
//   triggerpoint           pre-trigger sample count
//   wraddress_triggerpoint RAM write address at the trigger
//   data_ready             acquisition block holds a full record
//   ram_q                  RAM read data, channel i in bits [8i+7:8i], one cycle after rden
//   start_trigger          one-cycle pulse that starts an acquisition
//   rden, rdaddress        RAM read enable / address (address holds when idle)
//   tx_data, tx_valid,     byte stream to host
//   tx_ready
//   busy, done             not-IDLE flag (registered), end-of-readout pulse
//   state_dbg              current FSM state
//
// Handshake: a byte transfers on a rising clk edge where tx_valid and
// tx_ready are both high. tx_data and tx_valid stay stable from the cycle
// tx_valid rises until that transfer, and tx_valid is low the cycle after.
module acq_readout_ctrl #(
  parameter int ram_width = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arm,
  input  logic                 auto_rearm,
  input  logic                 abort,
  input  logic [3:0]           chan_mask,
  input  logic [ram_width-1:0] nsmp,
  input  logic [ram_width-1:0] triggerpoint,
  input  logic [ram_width-1:0] wraddress_triggerpoint,
  input  logic                 data_ready,
  input  logic [31:0]          ram_q,
  output logic                 start_trigger,
  output logic                 rden,
  output logic [ram_width-1:0] rdaddress,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           state_dbg
);

  typedef enum logic [2:0] {
    IDLE, ARM, WAIT_CLR, WAIT_RDY, FETCH, CAPT, SEND, NEXT
  } state_t;

  state_t               state, next_state;
  logic [ram_width-1:0] k, k_n;
  logic [ram_width-1:0] base, base_n;
  logic [ram_width-1:0] nsmp_l, nsmp_n;
  logic [3:0]           mask_l, mask_n;
  logic [1:0]           chan, chan_n;
  logic                 empty, empty_n;
  logic [1:0]           lo_chan;
  logic [1:0]           hi_chan;
  logic                 hi_found;
  logic                 k_more;
  logic [7:0]           ram_byte;

  assign state_dbg = state;
  assign ram_byte  = ram_q[{chan, 3'b000} +: 8];
  // One extra bit so k+1 cannot wrap when nsmp is at its maximum.
  assign k_more    = ({1'b0, k} + {{ram_width{1'b0}}, 1'b1}) < {1'b0, nsmp_l};

  // Lowest enabled channel of the incoming mask (first channel of a readout).
  always_comb begin
    lo_chan = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (chan_mask[i]) lo_chan = 2'(i);
    end
  end

  // Lowest enabled channel strictly above the current one, from the latched mask.
  always_comb begin
    hi_found = 1'b0;
    hi_chan  = chan;
    for (int i = 3; i >= 0; i--) begin
      if (mask_l[i] && (2'(i) > chan)) begin
        hi_found = 1'b1;
        hi_chan  = 2'(i);
      end
    end
  end

  always_comb begin
    next_state    = state;
    k_n           = k;
    chan_n        = chan;
    base_n        = base;
    nsmp_n        = nsmp_l;
    mask_n        = mask_l;
    empty_n       = empty;
    start_trigger = 1'b0;
    done          = 1'b0;
    case (state)
      IDLE:     if (arm) next_state = ARM;
      ARM: begin
        start_trigger = 1'b1;
        next_state    = WAIT_CLR;
      end
      // A data_ready left over from the previous record must drop first.
      WAIT_CLR: if (!data_ready) next_state = WAIT_RDY;
      WAIT_RDY: begin
        if (data_ready) begin
          base_n     = wraddress_triggerpoint - triggerpoint;
          nsmp_n     = nsmp;
          mask_n     = chan_mask;
          chan_n     = lo_chan;
          k_n        = '0;
          empty_n    = (chan_mask == 4'd0) || (nsmp == '0);
          next_state = empty_n ? NEXT : FETCH;
        end
      end
      FETCH:    next_state = CAPT;
      CAPT:     next_state = SEND;
      SEND:     if (tx_ready) next_state = NEXT;
      NEXT: begin
        if (!empty && k_more) begin
          k_n        = k + 1'b1;
          next_state = FETCH;
        end else if (!empty && hi_found) begin
          chan_n     = hi_chan;
          k_n        = '0;
          next_state = FETCH;
        end else begin
          done       = 1'b1;
          next_state = auto_rearm ? ARM : IDLE;
        end
      end
      default:  next_state = IDLE;
    endcase
    if (abort) begin
      next_state    = IDLE;
      start_trigger = 1'b0;
      done          = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      k         <= '0;
      chan      <= 2'd0;
      base      <= '0;
      nsmp_l    <= '0;
      mask_l    <= 4'd0;
      empty     <= 1'b0;
      rden      <= 1'b0;
      rdaddress <= '0;
      tx_data   <= 8'd0;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state  <= next_state;
      k      <= k_n;
      chan   <= chan_n;
      base   <= base_n;
      nsmp_l <= nsmp_n;
      mask_l <= mask_n;
      empty  <= empty_n;
      // Outputs are registered from next_state so they line up with the state.
      rden   <= (next_state == FETCH);
      if (next_state == FETCH) rdaddress <= base_n + k_n;
      if (state == CAPT && !abort) tx_data <= ram_byte;
      tx_valid <= (next_state == SEND);
      busy     <= (next_state != IDLE);
    end
  end

endmodule

// File: doc/acq_readout_ctrl.md
ACQ_READOUT_CTRL -- requirements
Module: acq_readout_ctrl

Interface
REQ-001 SHALL have parameter ram_width, default 10, sample RAM address width.
REQ-002 SHALL have ports: clk  input  1  system clock; all logic on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state.
REQ-004 arm  input  1  one-cycle pulse; requests one acquisition plus readout.
REQ-005 auto_rearm  input  1  when high, re-arm automatically after each readout completes.
REQ-006 abort  input  1  one-cycle pulse; cancels any operation and returns to IDLE.
REQ-007 chan_mask  input  4  channels to read out; bit i enables channel i.
REQ-008 nsmp  input  ram_width  samples read per enabled channel.
REQ-009 triggerpoint  input  ram_width  pre-trigger sample count.
REQ-010 wraddress_triggerpoint  input  ram_width  RAM address at which the trigger occurred.
REQ-011 data_ready  input  1  high when the acquisition block holds a full record.
REQ-012 ram_q  input  32  RAM read data; channel i on bits [8i+7:8i]; valid 1 cycle after rden.
REQ-013 start_trigger  output  1  one-cycle pulse starting an acquisition.
REQ-014 rden, rdaddress  output  1, ram_width  RAM read enable and address.
REQ-015 tx_data, tx_valid  output  8, 1  byte stream to host.
REQ-016 tx_ready  input  1  host accepts tx_data when tx_valid and tx_ready are both high.
REQ-017 busy, done  output  1, 1  busy high outside IDLE; done is a one-cycle pulse at readout end.

Function
REQ-018 States SHALL be IDLE, ARM, WAIT_CLR, WAIT_RDY, FETCH, CAPT, SEND, NEXT.
- IDLE: arm -> ARM.
- ARM: start_trigger=1 for exactly one cycle -> WAIT_CLR.
- WAIT_CLR: data_ready==0 -> WAIT_RDY. This blocks a stale data_ready from a previous record.
- WAIT_RDY: data_ready==1 -> latch base, set chan to the lowest set chan_mask bit and k=0 -> FETCH. If chan_mask==0 or nsmp==0, go straight to NEXT-end instead.
REQ-019 base SHALL be wraddress_triggerpoint - triggerpoint, computed modulo 2^ram_width (wraps below 0). chan_mask, nsmp and base SHALL be latched in WAIT_RDY and held for the whole readout.
REQ-020 Readout datapath:
- FETCH: rden=1, rdaddress=(base+k) mod 2^ram_width -> CAPT.
- CAPT: tx_data<=ram_q[8*chan+7:8*chan], tx_valid<=1 -> SEND.
- SEND: hold tx_data and tx_valid stable until tx_ready=1 -> NEXT.
REQ-021 NEXT:
- If k<nsmp-1: k+1 -> FETCH.
- Else if a higher enabled channel exists: chan=next enabled channel, k=0 -> FETCH.
- Else: done=1 for one cycle; if auto_rearm -> ARM, else -> IDLE.
REQ-022 tx_valid SHALL deassert in the cycle after the handshake; a byte SHALL never be dropped or duplicated.
REQ-023 rden SHALL be high only in FETCH, and rdaddress SHALL hold its last value otherwise.
REQ-024 Byte order SHALL be ascending channel, then ascending k. Total bytes = popcount(chan_mask)*nsmp.
REQ-025 Throughput SHALL be at most 1 byte per 4 cycles with tx_ready held high. First byte latency from data_ready rising = 3 cycles to tx_valid.
REQ-026 arm SHALL be ignored outside IDLE.
REQ-027 abort SHALL take priority over every other event in all states: next state IDLE, tx_valid=0, rden=0, no done pulse.
REQ-028 If arm and abort occur in the same IDLE cycle, abort SHALL win and the controller stays in IDLE.
REQ-029 busy SHALL be a registered output equal to (state!=IDLE).

Reset
REQ-030 Asserting reset SHALL immediately force IDLE, start_trigger=0, rden=0, rdaddress=0, tx_data=0, tx_valid=0, busy=0, done=0, and clear k and chan.
REQ-031 Reset asserted mid-readout SHALL discard the partial record; the first arm after release SHALL start a full new sequence.

Verification
REQ-032 ram_width=10, chan_mask=0001, nsmp=4, triggerpoint=2, wraddress_triggerpoint=100, tx_ready=1; arm -> one start_trigger pulse; after the data_ready low->high, reads addresses 98,99,100,101; 4 bytes from ram_q[7:0]; one done pulse.
REQ-033 Wrap: wraddress_triggerpoint=1, triggerpoint=3, nsmp=4 -> addresses 1022,1023,0,1.
REQ-034 chan_mask=1010, nsmp=2, tx_ready toggling 1-of-3 cycles -> 4 bytes in order ch1 k0, ch1 k1, ch3 k0, ch3 k1; tx_data stable while stalled.
REQ-035 data_ready already high at arm -> no readout until data_ready has gone low then high again.
REQ-036 auto_rearm=1 -> second start_trigger in the cycle after done; abort during SEND -> tx_valid=0 next cycle, IDLE, no done.
REQ-037 chan_mask=0000 -> done pulse with zero bytes; reset pulse during FETCH -> all outputs at reset values, busy=0.
